riscv_multicycle_control: RTL and testbench
===========================================

// Module: riscv_multicycle_control
// PURPOSE
// Multicycle RV32I control FSM; successor to the single-cycle opcode decoder. Sequences
// fetch/decode/execute/memory/writeback over a shared ALU and unified memory port.
// Adds a memory wait-state handshake, an illegal-opcode trap and a retired-instruction counter.
// Sits between the instruction register/flags of the datapath and its muxes/enables.
// PARAMETERS
// CNT_W     32  width of instret counter
// HAS_UPPER 1   1: LUI/AUIPC decoded; 0: treated as illegal
// HAS_JALR  1   1: JALR decoded; 0: treated as illegal
// PORTS
// clk            in  1      clock, rising edge
// rst_n          in  1      synchronous reset, active low
// opcode_i       in  7      instr[6:0] from instruction register
// funct3_i       in  3      instr[14:12]
// zero_i         in  1      ALU result == 0
// lt_i / ltu_i   in  1      signed / unsigned rs1<rs2 from ALU
// mem_ready_i    in  1      memory completes current access this cycle
// mem_req_o      out 1      memory access requested this cycle
// mem_write_o    out 1      store strobe (valid with mem_req_o)
// adr_src_o      out 1      0: PC, 1: ALUOut as memory address
// ir_write_o     out 1      load instruction register
// pc_write_o     out 1      load PC from result bus
// reg_write_o    out 1      register-file write enable
// alu_src_a_o    out 2      00 PC, 01 OldPC, 10 rs1, 11 zero
// alu_src_b_o    out 2      00 rs2, 01 imm, 10 const 4
// alu_op_o       out 2      00 add, 01 compare/sub, 10 funct-decoded
// result_src_o   out 2      00 ALUOut, 01 mem data, 10 ALUResult
// imm_src_o      out 3      000 I, 001 S, 010 B, 011 J, 100 U (combinational from opcode_i)
// illegal_o      out 1      one-cycle pulse on undecodable opcode
// instret_o      out CNT_W  retired-instruction count
// BEHAVIOUR
// States: FETCH DECODE MEMADR MEMREAD MEMWB MEMWRITE EXECR EXECI ALUWB BRANCH JAL JALR UPPER TRAP.
// Reset (rst_n=0 at edge): state=FETCH, instret=0; all enables/strobes 0, selects 00.
// Outputs are Moore decode of state, except pc_write_o in BRANCH and ir_write/pc_write in FETCH.
// FETCH: mem_req=1, adr_src=0, a=00, b=10, alu_op=00, result=10; hold while mem_ready=0;
//   on mem_ready=1: ir_write=1, pc_write=1, -> DECODE. No IR/PC update while waiting.
// DECODE: a=01, b=01, alu_op=00 (branch target to ALUOut); dispatch on opcode_i:
//   0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH;
//   1101111 -> JAL; 1100111 -> JALR; 0110111/0010111 -> UPPER; else -> TRAP.
// MEMADR: a=10, b=01, alu_op=00; -> MEMREAD (load) or MEMWRITE (store).
// MEMREAD: mem_req=1, adr_src=1; hold until mem_ready; -> MEMWB.
// MEMWB: result=01, reg_write=1; -> FETCH (retires).
// MEMWRITE: mem_req=1, mem_write=1, adr_src=1; hold until mem_ready; -> FETCH (retires).
// EXECR: a=10, b=00, alu_op=10; EXECI: a=10, b=01, alu_op=10; both -> ALUWB.
// ALUWB: result=00, reg_write=1; -> FETCH (retires).
// BRANCH: a=10, b=00, alu_op=01, result=00; pc_write = taken, where funct3
//   000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu, 010/011 never taken; -> FETCH (retires).
// JAL: a=01, b=10, alu_op=00, result=00, pc_write=1; -> ALUWB (rd=PC+4).
// JALR: a=10, b=01, alu_op=00, result=10, pc_write=1 is NOT used for rd; it is sequenced:
//   JALR computes rs1+imm to ALUOut, -> JAL-like cycle is not reused; instead JALR -> JAL
//   with result=00 loading PC from ALUOut and ALUOut<=OldPC+4, then ALUWB.
// UPPER: a=11 (LUI) or 01 (AUIPC), b=01, alu_op=00; -> ALUWB.
// TRAP: illegal_o=1 for exactly one cycle, no writes; -> FETCH; instret not incremented.
// instret_o increments by 1 on each retiring transition into FETCH; wraps 2^CNT_W-1 -> 0.
// imm_src_o: I for load/OP-IMM/JALR, S store, B branch, J JAL, U LUI/AUIPC, 000 otherwise.
// Reset mid-access (incl. a held MEMWRITE) returns to FETCH next edge; mem_req drops same edge.
// mem_ready_i is ignored in states without mem_req_o.
// TESTING
// Reset, mem_ready=1, opcode 0110011 -> FETCH,DECODE,EXECR,ALUWB,FETCH; reg_write 1 cycle; instret=1.
// Load 0000011, mem_ready low 3 cycles in MEMREAD -> MEMREAD held 4 cycles, single reg_write, mem_write=0.
// BEQ funct3=000 zero=1 -> pc_write=1 in BRANCH; zero=0 -> pc_write=0; instret +1 both.
// Opcode 1111111 -> TRAP, illegal_o pulses 1 cycle, instret unchanged, next state FETCH.
// rst_n=0 during MEMWRITE wait -> next cycle FETCH, all strobes 0, instret=0.
// CNT_W=4, retire 17 R-type instrs -> instret_o wraps to 1.

Source files
------------

// File: rtl/riscv_multicycle_control.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and a unified memory port, with memory wait states, an
// illegal-opcode trap and a retired-instruction counter.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// FETCH    | read instruction at PC, PC <= PC+4 when memory is ready
// DECODE   | dispatch on opcode, ALUOut <= OldPC + imm (branch target)
// MEMADR   | ALUOut <= rs1 + imm (load/store address)
// MEMREAD  | load access at ALUOut, wait for mem_ready_i
// MEMWB    | rd <= memory data, retire
// MEMWRITE | store access at ALUOut, wait for mem_ready_i, retire
// EXECR    | ALU on rs1, rs2 (funct-decoded)
// EXECI    | ALU on rs1, imm (funct-decoded)
// ALUWB    | rd <= ALUOut, retire
// BRANCH   | compare rs1/rs2, PC <= ALUOut when taken, retire
// JAL      | PC <= ALUOut (target), ALUOut <= OldPC + 4
// JALR     | ALUOut <= rs1 + imm, then reuse JAL
// UPPER    | ALUOut <= imm (LUI) or OldPC + imm (AUIPC)
// TRAP     | one-cycle illegal pulse, back to FETCH without retiring
module riscv_multicycle_control #(
    parameter int CNT_W     = 32,
    parameter int HAS_UPPER = 1,
    parameter int HAS_JALR  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode_i,
    input  logic [2:0]       funct3_i,
    input  logic             zero_i,
    input  logic             lt_i,
    input  logic             ltu_i,
    input  logic             mem_ready_i,
    output logic             mem_req_o,
    output logic             mem_write_o,
    output logic             adr_src_o,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic             reg_write_o,
    output logic [1:0]       alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [1:0]       alu_op_o,
    output logic [1:0]       result_src_o,
    output logic [2:0]       imm_src_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] instret_o
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR,
        EXECI, ALUWB, BRANCH, JAL, JALR, UPPER, TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    state_t           stateQ, stateD;
    logic             rstHoldQ;
    logic [CNT_W-1:0] instretQ;
    logic             retire;
    logic             branchTaken;
    logic             memReq, memWrite, adrSrc, irWrite, pcWrite, regWrite, illegal;
    logic [1:0]       aluSrcA, aluSrcB, aluOp, resultSrc;

    // Outputs stay quiet for the cycle following a reset edge, so a reset during
    // a held access drops mem_req on that same edge rather than re-requesting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateQ   <= FETCH;
            rstHoldQ <= 1'b1;
        end else begin
            stateQ   <= stateD;
            rstHoldQ <= 1'b0;
        end
    end

    // Retired-instruction counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instretQ <= '0;
        end else if (retire) begin
            instretQ <= instretQ + CNT_W'(1);
        end
    end

    // Branch condition from funct3 and ALU flags; 010/011 are never taken.
    always_comb begin
        branchTaken = 1'b0;
        case (funct3_i)
            3'b000:  branchTaken = zero_i;
            3'b001:  branchTaken = !zero_i;
            3'b100:  branchTaken = lt_i;
            3'b101:  branchTaken = !lt_i;
            3'b110:  branchTaken = ltu_i;
            3'b111:  branchTaken = !ltu_i;
            default: branchTaken = 1'b0;
        endcase
    end

    // Next-state and Moore output decode (FETCH and BRANCH also look at inputs).
    always_comb begin
        stateD    = stateQ;
        memReq    = 1'b0;
        memWrite  = 1'b0;
        adrSrc    = 1'b0;
        irWrite   = 1'b0;
        pcWrite   = 1'b0;
        regWrite  = 1'b0;
        illegal   = 1'b0;
        aluSrcA   = 2'b00;
        aluSrcB   = 2'b00;
        aluOp     = 2'b00;
        resultSrc = 2'b00;
        retire    = 1'b0;
        if (rstHoldQ) begin
            stateD = FETCH;
        end else begin
            case (stateQ)
                FETCH: begin
                    memReq    = 1'b1;
                    aluSrcB   = 2'b10;
                    resultSrc = 2'b10;
                    if (mem_ready_i) begin
                        irWrite = 1'b1;
                        pcWrite = 1'b1;
                        stateD  = DECODE;
                    end
                end
                DECODE: begin
                    aluSrcA = 2'b01;
                    aluSrcB = 2'b01;
                    case (opcode_i)
                        OP_LOAD, OP_STORE: stateD = MEMADR;
                        OP_R:              stateD = EXECR;
                        OP_IMM:            stateD = EXECI;
                        OP_BRANCH:         stateD = BRANCH;
                        OP_JAL:            stateD = JAL;
                        OP_JALR:           stateD = (HAS_JALR != 0) ? JALR : TRAP;
                        OP_LUI, OP_AUIPC:  stateD = (HAS_UPPER != 0) ? UPPER : TRAP;
                        default:           stateD = TRAP;
                    endcase
                end
                MEMADR: begin
                    aluSrcA = 2'b10;
                    aluSrcB = 2'b01;
                    stateD  = (opcode_i == OP_STORE) ? MEMWRITE : MEMREAD;
                end
                MEMREAD: begin
                    memReq = 1'b1;
                    adrSrc = 1'b1;
                    if (mem_ready_i) stateD = MEMWB;
                end
                MEMWB: begin
                    resultSrc = 2'b01;
                    regWrite  = 1'b1;
                    retire    = 1'b1;
                    stateD    = FETCH;
                end
                MEMWRITE: begin
                    memReq   = 1'b1;
                    memWrite = 1'b1;
                    adrSrc   = 1'b1;
                    if (mem_ready_i) begin
                        retire = 1'b1;
                        stateD = FETCH;
                    end
                end
                EXECR: begin
                    aluSrcA = 2'b10;
                    aluOp   = 2'b10;
                    stateD  = ALUWB;
                end
                EXECI: begin
                    aluSrcA = 2'b10;
                    aluSrcB = 2'b01;
                    aluOp   = 2'b10;
                    stateD  = ALUWB;
                end
                ALUWB: begin
                    regWrite = 1'b1;
                    retire   = 1'b1;
                    stateD   = FETCH;
                end
                BRANCH: begin
                    aluSrcA = 2'b10;
                    aluOp   = 2'b01;
                    pcWrite = branchTaken;
                    retire  = 1'b1;
                    stateD  = FETCH;
                end
                JAL: begin
                    aluSrcA = 2'b01;
                    aluSrcB = 2'b10;
                    pcWrite = 1'b1;
                    stateD  = ALUWB;
                end
                JALR: begin
                    // Only stages rs1+imm into ALUOut; the PC load happens in JAL.
                    aluSrcA   = 2'b10;
                    aluSrcB   = 2'b01;
                    resultSrc = 2'b10;
                    stateD    = JAL;
                end
                UPPER: begin
                    aluSrcA = (opcode_i == OP_LUI) ? 2'b11 : 2'b01;
                    aluSrcB = 2'b01;
                    stateD  = ALUWB;
                end
                TRAP: begin
                    illegal = 1'b1;
                    stateD  = FETCH;
                end
                default: stateD = FETCH;
            endcase
        end
    end

    // Immediate format follows the opcode directly, independent of state.
    always_comb begin
        imm_src_o = 3'b000;
        case (opcode_i)
            OP_STORE:  imm_src_o = 3'b001;
            OP_BRANCH: imm_src_o = 3'b010;
            OP_JAL:    imm_src_o = 3'b011;
            OP_LUI, OP_AUIPC: begin
                if (HAS_UPPER != 0) imm_src_o = 3'b100;
            end
            default:   imm_src_o = 3'b000;
        endcase
    end

    assign mem_req_o    = memReq;
    assign mem_write_o  = memWrite;
    assign adr_src_o    = adrSrc;
    assign ir_write_o   = irWrite;
    assign pc_write_o   = pcWrite;
    assign reg_write_o  = regWrite;
    assign illegal_o    = illegal;
    assign alu_src_a_o  = aluSrcA;
    assign alu_src_b_o  = aluSrcB;
    assign alu_op_o     = aluOp;
    assign result_src_o = resultSrc;
    assign instret_o    = instretQ;

endmodule

// File: tb/tb_riscv_multicycle_control.sv
// Directed bench for riscv_multicycle_control: a default instance plus a
// CNT_W=4, HAS_UPPER=0 instance sharing the same stimulus.
module tb_riscv_multicycle_control;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // strobe vector: {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal}
    localparam logic [6:0] S_FETCH_RDY  = 7'b1001100;
    localparam logic [6:0] S_FETCH_WAIT = 7'b1000000;
    localparam logic [6:0] S_NONE       = 7'b0000000;
    localparam logic [6:0] S_REGW       = 7'b0000010;
    localparam logic [6:0] S_MEMREAD    = 7'b1010000;
    localparam logic [6:0] S_MEMWRITE   = 7'b1110000;
    localparam logic [6:0] S_PCW        = 7'b0000100;
    localparam logic [6:0] S_TRAP       = 7'b0000001;
    // select vector: {alu_src_a, alu_src_b, alu_op, result_src}
    localparam logic [7:0] L_FETCH  = 8'b00100010;
    localparam logic [7:0] L_DECODE = 8'b01010000;
    localparam logic [7:0] L_EXECR  = 8'b10001000;
    localparam logic [7:0] L_MEMADR = 8'b10010000;
    localparam logic [7:0] L_MEMWB  = 8'b00000001;
    localparam logic [7:0] L_BRANCH = 8'b10000100;
    localparam logic [7:0] L_JAL    = 8'b01100000;
    localparam logic [7:0] L_JALR   = 8'b10010010;
    localparam logic [7:0] L_LUI    = 8'b11010000;
    localparam logic [7:0] L_AUIPC  = 8'b01010000;

    logic clk = 1'b0;
    logic rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic zero, lt, ltu, memReady;

    logic memReq, memWrite, adrSrc, irWrite, pcWrite, regWrite, illegal;
    logic [1:0] aluSrcA, aluSrcB, aluOp, resultSrc;
    logic [2:0] immSrc;
    logic [31:0] instret;

    logic memReq4, memWrite4, adrSrc4, irWrite4, pcWrite4, regWrite4, illegal4;
    logic [1:0] aluSrcA4, aluSrcB4, aluOp4, resultSrc4;
    logic [2:0] immSrc4;
    logic [3:0] instret4;

    logic [6:0] strb;
    logic [7:0] sel;
    assign strb = {memReq, memWrite, adrSrc, irWrite, pcWrite, regWrite, illegal};
    assign sel  = {aluSrcA, aluSrcB, aluOp, resultSrc};

    int errors = 0;
    int checks = 0;
    int expInstret = 0;

    always #5 clk = ~clk;

    riscv_multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode_i(opcode), .funct3_i(funct3),
        .zero_i(zero), .lt_i(lt), .ltu_i(ltu), .mem_ready_i(memReady),
        .mem_req_o(memReq), .mem_write_o(memWrite), .adr_src_o(adrSrc),
        .ir_write_o(irWrite), .pc_write_o(pcWrite), .reg_write_o(regWrite),
        .alu_src_a_o(aluSrcA), .alu_src_b_o(aluSrcB), .alu_op_o(aluOp),
        .result_src_o(resultSrc), .imm_src_o(immSrc), .illegal_o(illegal),
        .instret_o(instret)
    );

    riscv_multicycle_control #(.CNT_W(4), .HAS_UPPER(0), .HAS_JALR(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .opcode_i(opcode), .funct3_i(funct3),
        .zero_i(zero), .lt_i(lt), .ltu_i(ltu), .mem_ready_i(memReady),
        .mem_req_o(memReq4), .mem_write_o(memWrite4), .adr_src_o(adrSrc4),
        .ir_write_o(irWrite4), .pc_write_o(pcWrite4), .reg_write_o(regWrite4),
        .alu_src_a_o(aluSrcA4), .alu_src_b_o(aluSrcB4), .alu_op_o(aluOp4),
        .result_src_o(resultSrc4), .imm_src_o(immSrc4), .illegal_o(illegal4),
        .instret_o(instret4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; opcode = 7'd0; funct3 = 3'd0;
        zero = 1'b0; lt = 1'b0; ltu = 1'b0; memReady = 1'b1;
        tick(); tick();
        checks++;
        if (strb !== S_NONE || sel !== 8'd0) begin
            errors++; $display("FAIL reset_outputs strb=%b sel=%b want 0/0", strb, sel);
        end
        checks++;
        if (instret !== 32'd0 || instret4 !== 4'd0) begin
            errors++; $display("FAIL reset_instret got %0d/%0d want 0", instret, instret4);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (strb !== S_FETCH_RDY || sel !== L_FETCH) begin
            errors++; $display("FAIL reset_fetch strb=%b sel=%b want %b/%b", strb, sel, S_FETCH_RDY, L_FETCH);
        end
        memReady = 1'b0;
        expInstret = 0;
    endtask

    task automatic test_rtype();
        opcode = OP_R; memReady = 1'b1;
        tick();
        checks++;
        if (strb !== S_NONE || sel !== L_DECODE) begin
            errors++; $display("FAIL rtype_decode strb=%b sel=%b want %b/%b", strb, sel, S_NONE, L_DECODE);
        end
        tick();
        checks++;
        if (strb !== S_NONE || sel !== L_EXECR) begin
            errors++; $display("FAIL rtype_execr strb=%b sel=%b want %b/%b", strb, sel, S_NONE, L_EXECR);
        end
        tick();
        checks++;
        if (strb !== S_REGW || sel !== 8'd0) begin
            errors++; $display("FAIL rtype_aluwb strb=%b sel=%b want %b/0", strb, sel, S_REGW);
        end
        memReady = 1'b0;
        tick();
        expInstret++;
        checks++;
        if (strb !== S_FETCH_WAIT || instret !== 32'(expInstret)) begin
            errors++; $display("FAIL rtype_retire strb=%b instret=%0d want %b/%0d", strb, instret, S_FETCH_WAIT, expInstret);
        end
        tick();
        checks++;
        if (strb !== S_FETCH_WAIT || instret !== 32'(expInstret)) begin
            errors++; $display("FAIL fetch_wait_hold strb=%b instret=%0d want %b/%0d", strb, instret, S_FETCH_WAIT, expInstret);
        end
    endtask

    task automatic test_load_wait();
        int held = 0;
        int badWrite = 0;
        opcode = OP_LOAD; memReady = 1'b1;
        tick();
        checks++;
        if (immSrc !== 3'b000) begin
            errors++; $display("FAIL load_imm got %b want 000", immSrc);
        end
        memReady = 1'b0;
        tick();
        checks++;
        if (strb !== S_NONE || sel !== L_MEMADR) begin
            errors++; $display("FAIL load_memadr strb=%b sel=%b want %b/%b", strb, sel, S_NONE, L_MEMADR);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            if (strb === S_MEMREAD) held++;
            if (memWrite !== 1'b0) badWrite++;
            if (i == 3) memReady = 1'b1;
            tick();
        end
        checks++;
        if (held != 4 || badWrite != 0) begin
            errors++; $display("FAIL load_hold held=%0d writes=%0d want 4/0", held, badWrite);
        end
        checks++;
        if (strb !== S_REGW || sel !== L_MEMWB) begin
            errors++; $display("FAIL load_memwb strb=%b sel=%b want %b/%b", strb, sel, S_REGW, L_MEMWB);
        end
        memReady = 1'b0;
        tick();
        expInstret++;
        checks++;
        if (strb !== S_FETCH_WAIT || instret !== 32'(expInstret)) begin
            errors++; $display("FAIL load_retire strb=%b instret=%0d want %b/%0d", strb, instret, S_FETCH_WAIT, expInstret);
        end
    endtask

    task automatic test_branch();
        // {funct3, zero, lt, ltu, taken}
        logic [7:0] vec [8];
        vec[0] = {3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vec[1] = {3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[2] = {3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vec[3] = {3'b100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vec[4] = {3'b101, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vec[5] = {3'b110, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vec[6] = {3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vec[7] = {3'b010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 8; k++) begin
            opcode = OP_BRANCH; funct3 = vec[k][7:5]; memReady = 1'b1;
            tick();
            checks++;
            if (immSrc !== 3'b010) begin
                errors++; $display("FAIL branch_imm[%0d] got %b want 010", k, immSrc);
            end
            memReady = 1'b0;
            zero = vec[k][4]; lt = vec[k][3]; ltu = vec[k][2];
            tick();
            checks++;
            if (pcWrite !== vec[k][1] || sel !== L_BRANCH || regWrite !== 1'b0) begin
                errors++; $display("FAIL branch_taken[%0d] pc_write=%b sel=%b want %b/%b", k, pcWrite, sel, vec[k][1], L_BRANCH);
            end
            tick();
            expInstret++;
            checks++;
            if (strb !== S_FETCH_WAIT || instret !== 32'(expInstret)) begin
                errors++; $display("FAIL branch_retire[%0d] strb=%b instret=%0d want %b/%0d", k, strb, instret, S_FETCH_WAIT, expInstret);
            end
        end
        zero = 1'b0; lt = 1'b0; ltu = 1'b0; funct3 = 3'd0;
    endtask

    task automatic test_jalr();
        opcode = OP_JALR; memReady = 1'b1;
        tick();
        memReady = 1'b0;
        tick();
        checks++;
        if (strb !== S_NONE || sel !== L_JALR) begin
            errors++; $display("FAIL jalr_state strb=%b sel=%b want %b/%b", strb, sel, S_NONE, L_JALR);
        end
        tick();
        checks++;
        if (strb !== S_PCW || sel !== L_JAL) begin
            errors++; $display("FAIL jalr_jal strb=%b sel=%b want %b/%b", strb, sel, S_PCW, L_JAL);
        end
        tick();
        checks++;
        if (strb !== S_REGW) begin
            errors++; $display("FAIL jalr_aluwb strb=%b want %b", strb, S_REGW);
        end
        tick();
        expInstret++;
        checks++;
        if (instret !== 32'(expInstret)) begin
            errors++; $display("FAIL jalr_retire instret=%0d want %0d", instret, expInstret);
        end
    endtask

    task automatic test_trap();
        opcode = 7'b1111111; memReady = 1'b1;
        tick();
        memReady = 1'b0;
        tick();
        checks++;
        if (strb !== S_TRAP || sel !== 8'd0) begin
            errors++; $display("FAIL trap_pulse strb=%b sel=%b want %b/0", strb, sel, S_TRAP);
        end
        tick();
        checks++;
        if (strb !== S_FETCH_WAIT || instret !== 32'(expInstret)) begin
            errors++; $display("FAIL trap_return strb=%b instret=%0d want %b/%0d", strb, instret, S_FETCH_WAIT, expInstret);
        end
    endtask

    task automatic test_upper();
        opcode = OP_LUI; memReady = 1'b1;
        tick();
        checks++;
        if (immSrc !== 3'b100 || immSrc4 !== 3'b000) begin
            errors++; $display("FAIL lui_imm got %b/%b want 100/000", immSrc, immSrc4);
        end
        memReady = 1'b0;
        tick();
        checks++;
        if (sel !== L_LUI || illegal !== 1'b0 || illegal4 !== 1'b1) begin
            errors++; $display("FAIL lui_upper sel=%b ill=%b ill4=%b want %b/0/1", sel, illegal, illegal4, L_LUI);
        end
        tick(); tick();
        expInstret++;
        opcode = OP_AUIPC; memReady = 1'b1;
        tick();
        memReady = 1'b0;
        tick();
        checks++;
        if (sel !== L_AUIPC || strb !== S_NONE) begin
            errors++; $display("FAIL auipc_upper sel=%b strb=%b want %b/0", sel, strb, L_AUIPC);
        end
        tick(); tick();
        expInstret++;
        checks++;
        if (instret !== 32'(expInstret)) begin
            errors++; $display("FAIL upper_retire instret=%0d want %0d", instret, expInstret);
        end
    endtask

    task automatic test_store_reset();
        opcode = OP_STORE; memReady = 1'b1;
        tick();
        checks++;
        if (immSrc !== 3'b001) begin
            errors++; $display("FAIL store_imm got %b want 001", immSrc);
        end
        memReady = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (strb !== S_MEMWRITE) begin
            errors++; $display("FAIL store_hold strb=%b want %b", strb, S_MEMWRITE);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (strb !== S_NONE || sel !== 8'd0 || instret !== 32'd0) begin
            errors++; $display("FAIL store_reset strb=%b sel=%b instret=%0d want 0/0/0", strb, sel, instret);
        end
        rst_n = 1'b1;
        tick();
        expInstret = 0;
        checks++;
        if (strb !== S_FETCH_WAIT) begin
            errors++; $display("FAIL store_reset_fetch strb=%b want %b", strb, S_FETCH_WAIT);
        end
    endtask

    task automatic test_back_to_back();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        expInstret = 0;
        opcode = OP_R; memReady = 1'b1;
        for (int i = 0; i < 17; i++) begin
            tick(); tick(); tick(); tick();
            expInstret++;
            checks++;
            if (instret4 !== 4'(expInstret % 16) || instret !== 32'(expInstret)) begin
                errors++; $display("FAIL wrap[%0d] instret4=%0d instret=%0d want %0d/%0d", i, instret4, instret, expInstret % 16, expInstret);
            end
        end
        checks++;
        if (instret4 !== 4'd1 || strb !== S_FETCH_RDY) begin
            errors++; $display("FAIL wrap_final instret4=%0d strb=%b want 1/%b", instret4, strb, S_FETCH_RDY);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_wait();
        test_branch();
        test_jalr();
        test_trap();
        test_upper();
        test_store_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
